// File: rtl/sampler.sv
// Logic-analyser front end: 16-channel sampler with programmable strobe rate
// and run-length compression into a 16-bit word stream.
module sampler (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        compressor_overflow_error,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        wvalid
);

  localparam int unsigned CH_W   = 16;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned CMP_W  = 8;

  localparam logic [4:0]       ADDR_CTRL = 5'd0;
  localparam logic [4:0]       ADDR_DIV  = 5'd4;
  localparam logic [CNT_W-1:0] CNT_SAT   = 15'h7FFE;

  // Configuration registers
  logic             en_q, en_d;
  logic             en_prev_q;
  logic [2:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ovf_clr;

  // Input synchronizer and strobe divider
  logic [CH_W-1:0]  s_meta_q, s_sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             strobe;

  // Compressor comparison state
  logic [CMP_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [CMP_W-1:0] mask;
  logic [CMP_W-1:0] sample;

  // Words produced this cycle: w0 goes out next, w1 goes to the pending slot
  logic             w0_valid, w1_valid;
  logic [CH_W-1:0]  w0, w1;

  // Output stage
  logic [CH_W-1:0]  out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  logic             unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  assign out_data                  = out_data_q;
  assign out_valid                 = out_valid_q;
  assign compressor_overflow_error = ovf_q;

  // Register-port decode
  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    div_d   = div_q;
    ovf_clr = 1'b0;
    if (wvalid && (waddr == ADDR_CTRL)) begin
      en_d    = wdata[0];
      ovf_clr = wdata[1];
      mode_d  = wdata[4:2];
    end
    if (wvalid && (waddr == ADDR_DIV)) begin
      div_d = wdata[15:0];
    end
  end

  // Strobe divider: held at zero while disabled so the first enabled cycle strobes
  always_comb begin
    strobe    = en_q && (div_cnt_q == '0);
    div_cnt_d = div_cnt_q;
    if (!en_q) begin
      div_cnt_d = '0;
    end else if (strobe) begin
      div_cnt_d = div_q;
    end else begin
      div_cnt_d = DIV_W'(div_cnt_q - 16'd1);
    end
  end

  // Channel mask for the compressed modes
  always_comb begin
    mask = 8'h00;
    case (mode_q[1:0])
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    sample = s_sync_q[CMP_W-1:0] & mask;
  end

  // Compressor: decides which words a strobe (or a disable flush) produces
  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    w0_valid = 1'b0;
    w1_valid = 1'b0;
    w0       = '0;
    w1       = '0;
    if (!en_q) begin
      first_d = 1'b1;
      cnt_d   = '0;
      if (en_prev_q && (cnt_q != '0)) begin
        w0_valid = 1'b1;
        w0       = {1'b1, cnt_q};
      end
    end else if (strobe) begin
      if (mode_q[2]) begin
        w0_valid = 1'b1;
        w0       = s_sync_q;
      end else if (first_q) begin
        w0_valid = 1'b1;
        w0       = {8'h00, sample};
        prev_d   = sample;
        cnt_d    = '0;
        first_d  = 1'b0;
      end else if (sample == prev_q) begin
        if (cnt_q == CNT_SAT) begin
          w0_valid = 1'b1;
          w0       = 16'hFFFF;
          cnt_d    = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 15'd1);
        end
      end else begin
        prev_d = sample;
        cnt_d  = '0;
        if (cnt_q != '0) begin
          w0_valid = 1'b1;
          w0       = {1'b1, cnt_q};
          w1_valid = 1'b1;
          w1       = {8'h00, sample};
        end else begin
          w0_valid = 1'b1;
          w0       = {8'h00, sample};
        end
      end
    end
  end

  // Output arbitration: pending word has priority, new words collide with it and are dropped
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ovf_set      = 1'b0;
    if (pend_valid_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = pend_q;
      pend_valid_d = 1'b0;
      ovf_set      = w0_valid || w1_valid;
    end else if (w0_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = w0;
      if (w1_valid) begin
        pend_d       = w1;
        pend_valid_d = 1'b1;
      end
    end
    ovf_d = (ovf_clr ? 1'b0 : ovf_q) | ovf_set;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= 1'b0;
      en_prev_q    <= 1'b0;
      mode_q       <= '0;
      div_q        <= '0;
      s_meta_q     <= '0;
      s_sync_q     <= '0;
      div_cnt_q    <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b1;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      en_prev_q    <= en_q;
      mode_q       <= mode_d;
      div_q        <= div_d;
      s_meta_q     <= s;
      s_sync_q     <= s_meta_q;
      div_cnt_q    <= div_cnt_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sampler.sv
// Scoreboard bench for sampler: directed stimulus pushes expected words,
// a negedge monitor pops and compares each valid output word.
module tb_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        compressor_overflow_error;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  sampler dut (
    .clk                       (clk),
    .rst                       (rst),
    .s                         (s),
    .out_data                  (out_data),
    .out_valid                 (out_valid),
    .compressor_overflow_error (compressor_overflow_error),
    .waddr                     (waddr),
    .wdata                     (wdata),
    .wvalid                    (wvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    waddr  = a;
    wdata  = d;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every valid word must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%04h expected none", out_data);
      end else begin
        chk("out_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_ovf", 16'(compressor_overflow_error), 16'd0);
    rst = 1'b0;
    idle(6);
    chk("idle_valid", 16'(out_valid), 16'd0);

    // 8-channel RLE, DIV=2: first word, silent run of 4, then RLE + data
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8004);
    exp_q.push_back(16'h00A5);
    wr(5'd4, 32'd2);
    wr(5'd0, 32'h0000_000D);
    idle(12);
    s = 16'h00A5;
    idle(4);
    wr(5'd0, 32'h0);
    idle(6);

    // Raw 16-channel mode, DIV=0: one word per clock
    s = 16'h1234;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h1234);
    wr(5'd4, 32'd0);
    wr(5'd0, 32'h0000_0011);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("raw_valid_held", 16'(out_valid), 16'd1);
    end
    wr(5'd0, 32'h0);
    idle(2);
    chk("raw_stopped", 16'(out_valid), 16'd0);
    idle(4);

    // 1-channel RLE with toggling input: collision drops a data word
    s = 16'h0000;
    idle(3);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8003);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8004);
    wr(5'd0, 32'h0000_0001);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      s = ((i % 2) == 0) ? 16'h0001 : 16'h0000;
      @(negedge clk);
    end
    chk("ovf_set", 16'(compressor_overflow_error), 16'd1);
    idle(4);
    wr(5'd0, 32'h0000_0002);
    idle(1);
    chk("ovf_cleared", 16'(compressor_overflow_error), 16'd0);
    idle(4);

    // Long constant run: saturated RLE word then residual flush on disable
    s = 16'h005A;
    idle(3);
    exp_q.push_back(16'h005A);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h8001);
    wr(5'd0, 32'h0000_000D);
    idle(32767);
    wr(5'd0, 32'h0);
    idle(6);
    chk("ovf_quiet", 16'(compressor_overflow_error), 16'd0);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
